// File: rtl/if_stage_pipe_register.sv
// IF/ID pipeline register with valid/ready handshake, a 2-entry skid buffer,
// flush-to-NOP bubble injection and a saturating squash counter.
module if_stage_pipe_register #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] NOP_WORD   = 32'hE1A00000,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic [DATA_WIDTH-1:0] instruction_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  squash_count
);

  localparam logic [DATA_WIDTH-1:0] NOP_DATA = DATA_WIDTH'(NOP_WORD);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  logic                  main_valid_q, main_valid_d;
  logic [PC_WIDTH-1:0]   main_pc_q, main_pc_d;
  logic [DATA_WIDTH-1:0] main_instr_q, main_instr_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [CNT_WIDTH-1:0]  squash_count_q, squash_count_d;

  logic                  accept;
  logic                  consume;
  logic [CNT_WIDTH:0]    squash_sum;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;
  assign consume  = main_valid_q && out_ready && !freeze && !flush;

  // The extra top bit of the sum catches overflow so the counter can saturate.
  assign squash_sum = {1'b0, squash_count_q}
                    + {{CNT_WIDTH{1'b0}}, main_valid_q}
                    + {{CNT_WIDTH{1'b0}}, skid_valid_q};

  always_comb begin
    main_valid_d   = main_valid_q;
    main_pc_d      = main_pc_q;
    main_instr_d   = main_instr_q;
    skid_valid_d   = skid_valid_q;
    skid_pc_d      = skid_pc_q;
    skid_instr_d   = skid_instr_q;
    squash_count_d = squash_count_q;

    if (flush) begin
      main_valid_d   = 1'b0;
      skid_valid_d   = 1'b0;
      main_pc_d      = '0;
      main_instr_d   = NOP_DATA;
      squash_count_d = squash_sum[CNT_WIDTH] ? CNT_MAX : squash_sum[CNT_WIDTH-1:0];
    end else if (consume) begin
      if (skid_valid_q) begin
        main_pc_d    = skid_pc_q;
        main_instr_d = skid_instr_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_pc_d    = pc_in;
        main_instr_d = instruction_in;
      end else begin
        // Drained: the last pc/instruction stay visible behind out_valid=0.
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_pc_d    = pc_in;
        main_instr_d = instruction_in;
      end else begin
        skid_valid_d = 1'b1;
        skid_pc_d    = pc_in;
        skid_instr_d = instruction_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid_q   <= 1'b0;
      main_pc_q      <= '0;
      main_instr_q   <= NOP_DATA;
      skid_valid_q   <= 1'b0;
      skid_pc_q      <= '0;
      skid_instr_q   <= '0;
      squash_count_q <= '0;
    end else begin
      main_valid_q   <= main_valid_d;
      main_pc_q      <= main_pc_d;
      main_instr_q   <= main_instr_d;
      skid_valid_q   <= skid_valid_d;
      skid_pc_q      <= skid_pc_d;
      skid_instr_q   <= skid_instr_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign pc           = main_pc_q;
  assign instruction  = main_instr_q;
  assign occupancy    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign squash_count = squash_count_q;

endmodule

// File: tb/tb_if_stage_pipe_register.sv
// Bench for if_stage_pipe_register: directed scenarios plus random traffic,
// checked every cycle against a FIFO-of-entries reference model.
module tb_if_stage_pipe_register;

  localparam logic [31:0] NOP = 32'hE1A00000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst, flush, freeze, in_valid, out_ready;
  logic [31:0] pc_in, instruction_in;
  logic        in_ready, out_valid;
  logic [31:0] pc, instruction;
  logic [1:0]  occupancy;
  logic [7:0]  squash_count;

  logic        sat_rst, sat_flush, sat_in_valid;
  logic        sat_in_ready, sat_out_valid;
  logic [31:0] sat_pc, sat_instruction;
  logic [1:0]  sat_occupancy;
  logic [1:0]  sat_squash_count;

  int total = 0;
  int bad   = 0;

  entry_t      q[$];
  logic [31:0] m_pc, m_ins;
  int          m_squash;
  bit          m_accepted;

  always #5 clk = ~clk;

  if_stage_pipe_register dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .instruction_in(instruction_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc(pc), .instruction(instruction),
    .occupancy(occupancy), .squash_count(squash_count)
  );

  if_stage_pipe_register #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(sat_rst), .flush(sat_flush), .freeze(1'b0),
    .in_valid(sat_in_valid), .in_ready(sat_in_ready),
    .pc_in(32'h0000_0040), .instruction_in(32'h0000_00C0),
    .out_valid(sat_out_valid), .out_ready(1'b0),
    .pc(sat_pc), .instruction(sat_instruction),
    .occupancy(sat_occupancy), .squash_count(sat_squash_count)
  );

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the stage is a 2-deep FIFO; outputs show its head, or the last head once empty.
  task automatic model_edge();
    bit can_take, take_out;
    m_accepted = 1'b0;
    if (!rst) begin
      q.delete();
      m_pc = 0; m_ins = NOP; m_squash = 0;
    end else if (flush) begin
      m_squash = (m_squash + q.size() > 255) ? 255 : m_squash + q.size();
      q.delete();
      m_pc = 0; m_ins = NOP;
    end else begin
      can_take = q.size() < 2;
      take_out = q.size() > 0 && out_ready && !freeze;
      if (take_out) void'(q.pop_front());
      if (in_valid && can_take) begin
        q.push_back('{pc: pc_in, ins: instruction_in});
        m_accepted = 1'b1;
      end
      if (q.size() > 0) begin
        m_pc = q[0].pc; m_ins = q[0].ins;
      end
    end
  endtask

  task automatic check_all();
    check_output("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check_output("pc", 64'(pc), 64'(m_pc));
    check_output("instruction", 64'(instruction), 64'(m_ins));
    check_output("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check_output("occupancy", 64'(occupancy), 64'(q.size()));
    check_output("squash_count", 64'(squash_count), 64'(m_squash));
    check_output("skid_implies_main", 64'(dut.skid_valid_q && !dut.main_valid_q), 64'(0));
  endtask

  task automatic apply_stimulus();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic offer(input logic [31:0] p, input logic [31:0] i);
    in_valid = 1'b1; pc_in = p; instruction_in = i;
  endtask

  initial begin
    logic [31:0] cur_pc, cur_ins;

    rst = 1'b0; flush = 1'b0; freeze = 1'b0; out_ready = 1'b0;
    offer(32'h100, 32'hDEAD);
    sat_rst = 1'b0; sat_flush = 1'b0; sat_in_valid = 1'b0;

    // Reset with in_valid high
    apply_stimulus();
    apply_stimulus();
    check_output("rst_out_valid", 64'(out_valid), 64'(0));
    check_output("rst_pc", 64'(pc), 64'(0));
    check_output("rst_instr", 64'(instruction), 64'(NOP));
    check_output("rst_in_ready", 64'(in_ready), 64'(1));
    check_output("rst_squash", 64'(squash_count), 64'(0));

    // Streaming
    rst = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(32'(4 * i), 32'(32'hA0 + i));
      apply_stimulus();
      check_output("stream_pc", 64'(pc), 64'(4 * i));
      check_output("stream_instr", 64'(instruction), 64'(32'hA0 + i));
      check_output("stream_occ", 64'(occupancy), 64'(1));
      check_output("stream_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    apply_stimulus();
    check_output("drain_valid", 64'(out_valid), 64'(0));
    check_output("drain_instr_held", 64'(instruction), 64'(32'hA2));

    // Freeze with skid
    out_ready = 1'b0;
    offer(32'h04, 32'hB1);
    apply_stimulus();
    freeze = 1'b1; out_ready = 1'b1;
    offer(32'h08, 32'hB2);
    apply_stimulus();
    check_output("frz_pc_held", 64'(pc), 64'(32'h04));
    check_output("frz_occ2", 64'(occupancy), 64'(2));
    check_output("frz_in_ready", 64'(in_ready), 64'(0));
    offer(32'h0C, 32'hB3);
    apply_stimulus();
    check_output("frz_occ2_hold", 64'(occupancy), 64'(2));
    check_output("frz_pc_held2", 64'(pc), 64'(32'h04));
    freeze = 1'b0;
    apply_stimulus();
    check_output("rel_pc_08", 64'(pc), 64'(32'h08));
    apply_stimulus();
    check_output("rel_pc_0c", 64'(pc), 64'(32'h0C));
    check_output("rel_instr_0c", 64'(instruction), 64'(32'hB3));
    in_valid = 1'b0;
    apply_stimulus();
    check_output("rel_empty", 64'(occupancy), 64'(0));

    // Flush with a full buffer and a word offered
    out_ready = 1'b0;
    offer(32'h20, 32'hC0); apply_stimulus();
    offer(32'h24, 32'hC1); apply_stimulus();
    check_output("fl_occ2", 64'(occupancy), 64'(2));
    flush = 1'b1; offer(32'h28, 32'hC2);
    apply_stimulus();
    check_output("fl_valid", 64'(out_valid), 64'(0));
    check_output("fl_instr", 64'(instruction), 64'(NOP));
    check_output("fl_pc", 64'(pc), 64'(0));
    check_output("fl_occ", 64'(occupancy), 64'(0));
    check_output("fl_squash", 64'(squash_count), 64'(2));
    flush = 1'b0; in_valid = 1'b0;
    apply_stimulus();
    check_output("fl_word_dropped", 64'(out_valid), 64'(0));

    // Flush beats freeze
    offer(32'h30, 32'hD0); apply_stimulus();
    in_valid = 1'b0; freeze = 1'b1; flush = 1'b1;
    apply_stimulus();
    check_output("flfrz_squash", 64'(squash_count), 64'(3));
    check_output("flfrz_valid", 64'(out_valid), 64'(0));
    freeze = 1'b0; flush = 1'b0;

    // Mid-stall reset
    offer(32'h40, 32'hE0); apply_stimulus();
    offer(32'h44, 32'hE1); apply_stimulus();
    check_output("ms_occ2", 64'(occupancy), 64'(2));
    in_valid = 1'b0; rst = 1'b0;
    apply_stimulus();
    check_output("ms_occ", 64'(occupancy), 64'(0));
    check_output("ms_squash", 64'(squash_count), 64'(0));
    check_output("ms_instr", 64'(instruction), 64'(NOP));
    rst = 1'b1;

    // Saturation on the narrow-counter instance
    sat_rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sat_in_valid = 1'b1; sat_flush = 1'b0;
      apply_stimulus();
      sat_in_valid = 1'b0; sat_flush = 1'b1;
      apply_stimulus();
      check_output("sat_count", 64'(sat_squash_count), 64'(i > 3 ? 3 : i));
    end
    sat_flush = 1'b0;
    check_output("sat_final", 64'(sat_squash_count), 64'(3));

    // Random traffic against the model
    cur_pc = 32'h1000; cur_ins = $urandom;
    for (int n = 0; n < 600; n++) begin
      in_valid       = ($urandom % 4) != 0;
      pc_in          = cur_pc;
      instruction_in = cur_ins;
      out_ready      = ($urandom % 3) != 0;
      freeze         = ($urandom % 5) == 0;
      flush          = ($urandom % 16) == 0;
      rst            = ($urandom % 64) != 0;
      apply_stimulus();
      if (m_accepted) begin
        cur_pc  = cur_pc + 4;
        cur_ins = $urandom;
      end
    end

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage_pipe_register.md
Name: if_stage_pipe_register

Overview:
- Parametrised successor to the fixed 32-bit IF/ID stage register.
- Carries PC plus instruction word between fetch and decode.
- Adds a valid/ready handshake and a 2-entry skid buffer, so fetch can run one beat ahead of a stalled decode without losing words.
- Keeps the existing freeze/flush semantics: flush injects a NOP bubble, and a saturating counter records squashed entries for performance debug.

Parameters:
- PC_WIDTH, 32, width of pc_in/pc.
- DATA_WIDTH, 32, width of instruction_in/instruction.
- NOP_WORD, 32'hE1A00000, instruction value presented while empty/flushed (MOV r0,r0); truncated/zero-extended to DATA_WIDTH.
- CNT_WIDTH, 8, width of squash_count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on rising clk).
- flush  in  1  squash all held entries (branch taken).
- freeze  in  1  hold output stage (hazard stall); equivalent to out_ready=0.
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  stage can accept a word this cycle.
- pc_in  in  PC_WIDTH  fetch PC.
- instruction_in  in  DATA_WIDTH  fetched instruction.
- out_valid  out  1  pc/instruction hold a live entry.
- out_ready  in  1  decode consumes this cycle.
- pc  out  PC_WIDTH  registered PC to decode.
- instruction  out  DATA_WIDTH  registered instruction to decode.
- occupancy  out  2  live entries held (0..2).
- squash_count  out  CNT_WIDTH  saturating count of live entries discarded by flush.

Behaviour:
- Storage: main register (drives outputs) plus skid register; each has a valid bit. All outputs are registered; no combinational path from inputs to outputs except none.
- in_ready = !skid_valid (registered state only; independent of out_ready, flush and freeze).
- accept = in_valid & in_ready & !flush.
- consume = out_valid & out_ready & !freeze & !flush.
- Reset (rst=0 on a clock edge), priority over everything:
  - main_valid=0, skid_valid=0, pc=0, instruction=NOP_WORD, squash_count=0, occupancy=0, in_ready=1.
- Flush (rst=1, flush=1), priority over freeze/accept/consume:
  - Both valids clear; pc=0, instruction=NOP_WORD.
  - Input in that cycle is dropped even if in_valid=1.
  - squash_count += main_valid + skid_valid, saturating at all-ones.
- Normal update, otherwise:
  - main empty, accept: load main. Latency 1 cycle: in at edge N, visible on outputs after edge N.
  - main full, consume, no accept: main <= skid if skid_valid, else main_valid=0 (pc/instruction hold last value; instruction not forced to NOP).
  - main full, consume & accept (skid necessarily empty): main <= input.
  - main full, no consume, accept: skid <= input; in_ready falls next cycle.
  - skid full & consume: main <= skid, skid_valid=0; no accept possible that cycle.
  - Neither event: hold all state.
- Ordering: entries leave strictly in acceptance order; no duplication or loss except by flush/reset.
- freeze=1 with out_valid: pc/instruction/out_valid held stable; at most one further word accepted (into skid).
- occupancy = main_valid + skid_valid.
- Invariant: skid_valid implies main_valid. Bench asserts it every cycle.

Test Plan:
- Reset: drive rst=0 for 2 cycles with in_valid=1 -> out_valid=0, pc=0, instruction=0xE1A00000, in_ready=1, squash_count=0.
- Streaming: out_ready=1, feed PCs 0x00,0x04,0x08 with instructions 0xA0,0xA1,0xA2 back-to-back -> each appears one cycle later; out_valid continuous; occupancy=1.
- Freeze skid:
  - Steps: main holds 0x04; freeze=1 while 0x08 and 0x0C are offered.
  - Required: 0x08 enters skid; in_ready=0 next cycle; 0x0C is not taken and fetch holds it; occupancy=2.
  - On release: 0x04, 0x08, 0x0C drain in order, one per cycle.
- Flush with full buffer: occupancy=2, flush=1 and in_valid=1 same cycle -> next cycle out_valid=0, instruction=0xE1A00000, pc=0, occupancy=0, squash_count=2; input word not present afterwards.
- Flush vs freeze: freeze=1 and flush=1 together with main full -> flush wins; squash_count +1.
- Saturation, CNT_WIDTH=2: squash 5 single entries -> squash_count=3.
- Mid-stall reset: occupancy=2, rst=0 one cycle -> all state at reset values; squash_count=0, not incremented.
